// File: rtl/vedic_mac_accum.sv
// vedic_mac_accum: sums len products from prod_valid/prod_ready, returns the sum on res_valid/res_ready with sticky carry ovf and busy
module vedic_mac_accum #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  input  logic              res_ready,
  output logic              ovf,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_n;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic [ACC_W:0] sum;
  logic xfer;
  assign prod_ready = state == ACCUM;
  assign res_valid = state == DONE;
  assign busy = state != IDLE;
  assign res_data = acc;
  assign xfer = prod_valid && prod_ready;
  assign sum = {1'b0, acc} + (ACC_W + 1)'(prod_data);
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = start ? (len == '0 ? DONE : ACCUM) : IDLE;
    else if (state == ACCUM)
      state_n = (xfer && remaining == CNT_W'(1)) ? DONE : ACCUM;
    else
      state_n = res_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      remaining <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        acc <= '0;
        ovf <= 1'b0;
        remaining <= len;
      end else if (xfer) begin
        acc <= sum[ACC_W-1:0];
        ovf <= ovf | sum[ACC_W];
        remaining <= remaining - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_vedic_mac_accum.sv
// tb_vedic_mac_accum: scoreboard bench for vedic_mac_accum with an 11-bit accumulator
module tb_vedic_mac_accum;
  localparam int ACC_W = 11;
  localparam int MOD = 1 << ACC_W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] len = '0;
  logic prod_valid = 1'b0;
  logic [7:0] prod_data = '0;
  logic prod_ready;
  logic res_valid;
  logic [ACC_W-1:0] res_data;
  logic res_ready = 1'b0;
  logic ovf;
  logic busy;
  typedef struct {int sum; bit ovf;} exp_t;
  exp_t exp_q[$];
  int vectors = 0;
  int errors = 0;
  vedic_mac_accum #(.PROD_W(8), .ACC_W(ACC_W), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .ovf(ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        chk("res_data", int'(res_data), exp_q[0].sum);
        chk("res_ovf", int'(ovf), int'(exp_q[0].ovf));
        if (res_ready) void'(exp_q.pop_front());
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int p);
    prod_valid = 1'b1;
    prod_data = 8'(p);
    chk("prod_ready", int'(prod_ready), 1);
    step();
    prod_valid = 1'b0;
  endtask
  task automatic collect(input int hold);
    res_ready = 1'b0;
    repeat (hold) step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("res_valid_after_handshake", int'(res_valid), 0);
    chk("busy_after_handshake", int'(busy), 0);
  endtask
  task automatic run(input int p[$], input int gap, input int hold);
    int total = 0;
    foreach (p[i]) total += p[i];
    exp_q.push_back('{total % MOD, total >= MOD});
    start = 1'b1;
    len = 4'(p.size());
    step();
    start = 1'b0;
    len = 4'($urandom_range(0, 15));
    chk("busy_after_start", int'(busy), 1);
    chk("prod_ready_len", int'(prod_ready), int'(p.size() != 0));
    foreach (p[i]) begin
      prod_data = 8'($urandom);
      repeat (gap) step();
      send(p[i]);
    end
    chk("res_valid_latency", int'(res_valid), 1);
    collect(hold);
    chk("ovf_sticky", int'(ovf), int'(total >= MOD));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int q[$];
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom);
      len = 4'($urandom);
      prod_valid = 1'($urandom);
      prod_data = 8'($urandom);
      res_ready = 1'($urandom);
      step();
      chk("rst_prod_ready", int'(prod_ready), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res_data", int'(res_data), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_busy", int'(busy), 0);
    end
    start = 1'b0;
    prod_valid = 1'b0;
    res_ready = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_busy", int'(busy), 0);
    chk("idle_res_valid", int'(res_valid), 0);
    run('{6, 20, 225}, 0, 0);
    run('{0, 0, 1, 255}, 2, 5);
    exp_q.push_back('{0, 1'b0});
    start = 1'b1;
    len = 4'd0;
    step();
    chk("zero_prod_ready", int'(prod_ready), 0);
    chk("zero_res_valid", int'(res_valid), 1);
    step();
    chk("done_start_ignored", int'(res_valid), 1);
    res_ready = 1'b1;
    step();
    start = 1'b0;
    res_ready = 1'b0;
    chk("handshake_start_ignored", int'(busy), 0);
    q = {};
    for (int i = 0; i < 15; i++) q.push_back(225);
    run(q, 0, 1);
    run('{6}, 0, 0);
    start = 1'b1;
    len = 4'd5;
    step();
    start = 1'b0;
    send(20);
    send(30);
    start = 1'b1;
    len = 4'd1;
    step();
    start = 1'b0;
    chk("midrun_busy", int'(busy), 1);
    chk("midrun_prod_ready", int'(prod_ready), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_prod_ready", int'(prod_ready), 0);
    chk("async_res_valid", int'(res_valid), 0);
    chk("async_res_data", int'(res_data), 0);
    chk("async_ovf", int'(ovf), 0);
    chk("async_busy", int'(busy), 0);
    step();
    rst_n = 1'b1;
    step();
    run('{20}, 0, 0);
    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(0, 15);
      q = {};
      for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 255));
      run(q, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
